// File: rtl/maxpool2x2_stride2_16channel_pkg.sv
// Shared constants and the fp32 ordering key used by the 2x2 max-pool block.
// The key maps IEEE-754 singles onto unsigned integers that sort like the floats.
package maxpool2x2_stride2_16channel_pkg;

    localparam int DEF_DATA_WIDHT = 32;
    localparam int DEF_CHANNELS   = 16;
    localparam int DEF_IMG_WIDHT  = 44;
    localparam int DEF_IMG_HEIGHT = 44;

    // Negative values are bit-inverted so larger magnitudes sort lower; -0 lands just below +0.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/maxpool2x2_stride2_16channel_fp32_max2.sv
// Combinational max of two fp32 values; on equal keys the first operand wins.
module fp32_max2
    import maxpool2x2_stride2_16channel_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = (fp32_key(b) > fp32_key(a)) ? b : a;

endmodule

// File: rtl/maxpool2x2_stride2_16channel.sv
// 2x2 stride-2 max pooling over a raster stream of packed fp32 channels.
// Even rows fold pairs into a half-width line buffer; odd rows finish the window.
module maxpool2x2_stride2_16channel
    import maxpool2x2_stride2_16channel_pkg::*;
#(
    parameter int DATA_WIDHT = DEF_DATA_WIDHT,
    parameter int IMG_WIDHT  = DEF_IMG_WIDHT,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CHANNELS   = DEF_CHANNELS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
    input  logic                           Valid_In,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out
);

    localparam int BUS_W    = DATA_WIDHT * CHANNELS;
    localparam int CW       = (IMG_WIDHT  > 1) ? $clog2(IMG_WIDHT)  : 1;
    localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = (IMG_WIDHT / 2 > 0) ? IMG_WIDHT / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [BUS_W-1:0] hold_q, hold_d;
    logic [BUS_W-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    logic [BUS_W-1:0] linebuf_q [LB_DEPTH];
    logic [LB_AW-1:0] lb_idx;
    logic [BUS_W-1:0] lb_rd;
    logic [BUS_W-1:0] pair_max;
    logic [BUS_W-1:0] win_max;
    logic             col_last, row_last;

    assign col_last = (col_q == CW'(IMG_WIDHT - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = linebuf_q[lb_idx];

    // pair_max feeds both the line-buffer write (even row) and the final compare (odd row).
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        fp32_max2 u_pair (
            .a (hold_q [k*DATA_WIDHT +: DATA_WIDHT]),
            .b (Data_In[k*DATA_WIDHT +: DATA_WIDHT]),
            .y (pair_max[k*DATA_WIDHT +: DATA_WIDHT])
        );
        fp32_max2 u_win (
            .a (lb_rd   [k*DATA_WIDHT +: DATA_WIDHT]),
            .b (pair_max[k*DATA_WIDHT +: DATA_WIDHT]),
            .y (win_max [k*DATA_WIDHT +: DATA_WIDHT])
        );
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        data_d = data_q;
        vld_d  = 1'b0;
        if (Valid_In) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                hold_d = Data_In;
            end else if (row_q[0]) begin
                data_d = win_max;
                vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            hold_q <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (Valid_In && col_q[0] && !row_q[0]) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    assign Data_Out  = data_q;
    assign Valid_Out = vld_q;

endmodule

// File: tb/tb_maxpool2x2_stride2_16channel.sv
// Directed bench for the 2x2 max-pool: 4x4 and 5x5 instances with hand-derived results.
module tb_maxpool2x2_stride2_16channel;

    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] din4 = '0, din5 = '0;
    logic          vin4 = 1'b0, vin5 = 1'b0;
    logic [BW-1:0] dout4, dout5;
    logic          vout4, vout5;

    always #5 clk = ~clk;

    maxpool2x2_stride2_16channel #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(4), .CHANNELS(16)) u4 (
        .clk(clk), .rst(rst), .Data_In(din4), .Valid_In(vin4), .Data_Out(dout4), .Valid_Out(vout4)
    );

    maxpool2x2_stride2_16channel #(.DATA_WIDHT(32), .IMG_WIDHT(5), .IMG_HEIGHT(5), .CHANNELS(16)) u5 (
        .clk(clk), .rst(rst), .Data_In(din5), .Valid_In(vin5), .Data_Out(dout5), .Valid_Out(vout5)
    );

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [BW-1:0] last4  = '0;
    logic [BW-1:0] last5  = '0;
    logic [31:0]   win0 [4];
    logic [31:0]   lit0 [4];
    logic [31:0]   lit3 [4];

    task automatic chk_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact conversion of a small non-negative integer to fp32.
    function automatic logic [31:0] i2f(input int n);
        int          e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if ((n >> i) != 0) e = i;
        m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [BW-1:0] pix_bus(input int r, input int c, input int w);
        logic [BW-1:0] b;
        for (int k = 0; k < 16; k++) b[k*32 +: 32] = i2f(r * w + c + k * 100);
        return b;
    endfunction

    task automatic idle(input int sel, input string nm);
        if (sel == 4) vin4 = 1'b0; else vin5 = 1'b0;
        @(posedge clk); #1;
        if (sel == 4) begin
            chk_eq({nm, "_idle_vld"}, BW'(vout4), '0);
            chk_eq({nm, "_idle_hold"}, dout4, last4);
        end else begin
            chk_eq({nm, "_idle_vld"}, BW'(vout5), '0);
            chk_eq({nm, "_idle_hold"}, dout5, last5);
        end
    endtask

    task automatic run_frame(input int sel, input int w, input int h, input int npix,
                             input bit gaps, input bit lit, input bit use_win,
                             input logic [31:0] wexp, input string nm);
        int            np;
        int            p;
        logic [BW-1:0] bus, expb, got_d;
        logic          got_v;
        bit            pulse;
        np = 0;
        p  = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (p < npix) begin
                    if (gaps) repeat ($urandom_range(0, 2)) idle(sel, nm);
                    bus = pix_bus(r, c, w);
                    if (use_win && r < 2 && c < 2) bus[31:0] = win0[r*2 + c];
                    if (sel == 4) begin din4 = bus; vin4 = 1'b1; end
                    else          begin din5 = bus; vin5 = 1'b1; end
                    @(posedge clk); #1;
                    got_v = (sel == 4) ? vout4 : vout5;
                    got_d = (sel == 4) ? dout4 : dout5;
                    pulse = (r % 2 == 1) && (c % 2 == 1);
                    chk_eq({nm, "_vld"}, BW'(got_v), BW'(pulse));
                    if (pulse) begin
                        expb = pix_bus(r, c, w);
                        if (use_win && r == 1 && c == 1) expb[31:0] = wexp;
                        chk_eq({nm, "_data"}, got_d, expb);
                        if (lit && np < 4) begin
                            chk_eq({nm, "_ch0"}, BW'(got_d[31:0]),  BW'(lit0[np]));
                            chk_eq({nm, "_ch3"}, BW'(got_d[127:96]), BW'(lit3[np]));
                        end
                        if (sel == 4) last4 = expb; else last5 = expb;
                        np++;
                    end else begin
                        chk_eq({nm, "_hold"}, got_d, (sel == 4) ? last4 : last5);
                    end
                    p++;
                end
            end
        end
        if (npix >= w * h) chk_eq({nm, "_count"}, BW'(np), BW'((w / 2) * (h / 2)));
    endtask

    task automatic do_reset(input string nm);
        vin4 = 1'b0;
        vin5 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_eq({nm, "_vld4"},  BW'(vout4), '0);
        chk_eq({nm, "_data4"}, dout4, '0);
        chk_eq({nm, "_vld5"},  BW'(vout5), '0);
        chk_eq({nm, "_data5"}, dout5, '0);
        repeat (2) begin
            @(posedge clk); #1;
            chk_eq({nm, "_vld_in_rst"}, BW'(vout4), '0);
        end
        #3 rst = 1'b0;
        last4 = '0;
        last5 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lit0 = '{32'h40A0_0000, 32'h40E0_0000, 32'h4150_0000, 32'h4170_0000};
        lit3 = '{32'h4398_8000, 32'h4399_8000, 32'h439C_8000, 32'h439D_8000};

        #1;
        do_reset("reset");

        run_frame(4, 4, 4, 16, 1'b0, 1'b1, 1'b0, 32'h0, "cont4");
        idle(4, "cont4_end");

        win0 = '{32'hBF80_0000, 32'hC000_0000, 32'hBF00_0000, 32'hC040_0000};
        run_frame(4, 4, 4, 16, 1'b0, 1'b0, 1'b1, 32'hBF00_0000, "neg");

        win0 = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        run_frame(4, 4, 4, 16, 1'b0, 1'b0, 1'b1, 32'h0000_0000, "zero_pos");

        win0 = '{32'h8000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        run_frame(4, 4, 4, 16, 1'b0, 1'b0, 1'b1, 32'h8000_0000, "zero_neg");
        idle(4, "zero_end");

        run_frame(4, 4, 4, 16, 1'b1, 1'b1, 1'b0, 32'h0, "gaps");
        idle(4, "gaps_end");

        run_frame(4, 4, 4, 6, 1'b0, 1'b0, 1'b0, 32'h0, "partial");
        do_reset("midrst");
        idle(4, "post_rst");
        run_frame(4, 4, 4, 16, 1'b0, 1'b1, 1'b0, 32'h0, "after_rst");
        idle(4, "after_rst_end");

        run_frame(5, 5, 5, 25, 1'b0, 1'b0, 1'b0, 32'h0, "odd_f1");
        run_frame(5, 5, 5, 25, 1'b0, 1'b0, 1'b0, 32'h0, "odd_f2");
        idle(5, "odd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
